// File: rtl/ckegen_multi.sv
// ckegen_multi: multi-channel programmable clock-enable generator with periodic and
// retriggerable one-shot modes. Define CKEGEN_CASCADE_EN to chain channels as a prescaler cascade.
module ckegen_multi #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 26,
    parameter int DEFAULT_T = 50000000
) (
    input  logic                                              clk,
    input  logic                                              rst_,
    input  logic                                              ena,
    input  logic                                              wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
    input  logic [WIDTH-1:0]                                  wr_period,
    input  logic                                              wr_oneshot,
    input  logic [CHANNELS-1:0]                               start,
    output logic [CHANNELS-1:0]                               cke,
    output logic [CHANNELS-1:0]                               busy,
    output logic [2*CHANNELS-1:0]                             dbg_state
);

    // RUN is periodic mode; IDLE/ARMED are the two one-shot states, so the mode is implied by the state.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_T);
    localparam logic [WIDTH-1:0] DEF_RELOAD = WIDTH'(DEFAULT_T - 1);

    state_t             state_q  [CHANNELS];
    state_t             state_d  [CHANNELS];
    logic [WIDTH-1:0]   period_q [CHANNELS];
    logic [WIDTH-1:0]   period_d [CHANNELS];
    logic [WIDTH-1:0]   cnt_q    [CHANNELS];
    logic [WIDTH-1:0]   cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] cke_q;
    logic [CHANNELS-1:0] cke_d;
    logic [CHANNELS-1:0] cnt_en;
    logic [CHANNELS-1:0] wr_hit;

    // A period of zero behaves as a period of one.
    function automatic logic [WIDTH-1:0] reload_of(input logic [WIDTH-1:0] p);
        return (p == '0) ? '0 : (p - WIDTH'(1));
    endfunction

    always_comb begin
        cnt_en = {CHANNELS{ena}};
`ifdef CKEGEN_CASCADE_EN
        for (int i = 1; i < CHANNELS; i++) begin
            cnt_en[i] = ena && cke_q[i-1];
        end
`endif
    end

    always_comb begin
        cke_d  = '0;
        wr_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            state_d[i]  = state_q[i];
            wr_hit[i]   = wr_en && (32'(wr_ch) == 32'(i));

            if (wr_hit[i]) begin
                period_d[i] = wr_period;
                cnt_d[i]    = reload_of(wr_period);
                state_d[i]  = wr_oneshot ? ST_IDLE : ST_RUN;
            end else if (start[i]) begin
                cnt_d[i] = reload_of(period_q[i]);
                if (state_q[i] != ST_RUN) begin
                    state_d[i] = ST_ARMED;
                end
            end else if (cnt_en[i] && (state_q[i] != ST_IDLE)) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end else begin
                    cnt_d[i] = reload_of(period_q[i]);
                    cke_d[i] = 1'b1;
                    if (state_q[i] == ST_ARMED) begin
                        state_d[i] = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cke_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_RUN;
                period_q[i] <= DEF_PERIOD;
                cnt_q[i]    <= DEF_RELOAD;
            end
        end else begin
            cke_q <= cke_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    always_comb begin
        busy      = '0;
        dbg_state = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i]            = (state_q[i] == ST_ARMED);
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign cke = cke_q;

endmodule
